regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: data width of registers, imm and bus.
REQ-002 SHALL provide parameter DEPTH, default 4, power of two ≥2: number of registers; AW = clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port grst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port instr  input  4+2*AW  instruction {op[3:0], rd[AW-1:0], rs[AW-1:0]}, rd in upper AW bits after op.
REQ-006 SHALL have port instr_valid  input  1  instr presented this cycle.
REQ-007 SHALL have port ready  output  1  block accepts instr this cycle.
REQ-008 SHALL have port imm  input  WIDTH  immediate operand.
REQ-009 SHALL have port bus  inout  WIDTH  shared tristate data bus.
REQ-010 SHALL have port zero  output  1  registered flag, last written result == 0.
REQ-011 SHALL have port illegal  output  1  one-cycle pulse, undefined opcode accepted.

Function
REQ-012 Accept = instr_valid && ready at a rising edge; instr ignored when ready=0, no queueing.
REQ-013 States: IDLE (ready=1), DRIVE (ready=0), SWAP2 (ready=0); every non-IDLE state lasts exactly one cycle, then IDLE.
REQ-014 op 0 NOP: no state change, stay IDLE.
REQ-015 op 1 LDI: R[rd] <= imm at accept edge; zero <= (imm==0).
REQ-016 op 2 RD: capture R[rs] into out_q at accept edge, go DRIVE; bus = out_q during DRIVE only, else bus = high-Z.
REQ-017 op 3 WR: R[rd] <= bus sampled at accept edge; zero updated.
REQ-018 op 4 MOV: R[rd] <= R[rs]; rd==rs legal, no change in value; zero updated.
REQ-019 op 5 CLR: all R <= 0, zero <= 1 (local reset, same effect on registers as grst).
REQ-020 op 6 SWAP: accept edge tmp <= R[rd], R[rd] <= R[rs], go SWAP2; SWAP2 edge R[rs] <= tmp; zero from final R[rs]; rd==rs leaves register unchanged.
REQ-021 op 7 INC: R[rd] <= R[rd]+1 modulo 2^WIDTH (all-ones wraps to 0, zero <= 1).
REQ-022 op 8-15: treated as NOP; illegal = 1 for the cycle after the accept edge, else 0.
REQ-023 Ops not listed as updating zero SHALL hold it.
REQ-024 Block SHALL never drive bus in IDLE or SWAP2; external drivers own bus then.
REQ-025 Reads for MOV/SWAP/INC SHALL use register values before the same edge's write.

Reset
REQ-026 grst=0 at an edge: all R = 0, tmp = 0, out_q = 0, state IDLE, zero = 1, illegal = 0, bus high-Z from the next cycle, ready = 1 after the edge.
REQ-027 grst SHALL override any concurrent accept and abort DRIVE or SWAP2 mid-operation (SWAP second half not performed).
REQ-028 instr_valid during the reset cycle SHALL be ignored.

Verification (WIDTH=4, DEPTH=4, instr 8 bits)
REQ-029 Reset then LDI R2=0xA (instr 0x18), RD R2 (0x22) -> ready 0 one cycle, bus=0xA in that cycle only, high-Z otherwise, zero=0.
REQ-030 R0=0x3, R1=0xC; SWAP rd=0 rs=1 (0x61) -> ready low one cycle, afterwards R0=0xC, R1=0x3 verified via RD; instr_valid held high during SWAP2 not accepted.
REQ-031 LDI R3=0xF, INC R3 (0x7C) -> R3=0x0, zero=1; second INC -> R3=0x1, zero=0.
REQ-032 External driver bus=0x5, WR R1 (0x34) -> R1=0x5; then op 0xB accepted -> illegal=1 exactly one cycle, no register change.
REQ-033 SWAP issued, grst=0 on SWAP2 edge -> all registers 0, state IDLE, ready=1, zero=1, bus high-Z; CLR after LDIs -> all R read back 0.
REQ-034 Randomised op stream against a reference model at DEPTH=8, WIDTH=8 -> zero mismatches, bus never driven outside DRIVE.

Source files
------------

// File: rtl/regfile_param.sv
// Parameterised register file with tristate bus; LDI/WR/MOV/CLR/INC take effect at the accept edge.
// RD drives bus for one DRIVE cycle, SWAP finishes in SWAP2; ready=0 in both, and instr is dropped while ready=0.
module regfile_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              grst,
  input  logic [3+2*AW:0]   instr,
  input  logic              instr_valid,
  output logic              ready,
  input  logic [WIDTH-1:0]  imm,
  inout  wire  [WIDTH-1:0]  bus,
  output logic              zero,
  output logic              illegal
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SWAP2} state_t;

  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_RD   = 4'd2;
  localparam logic [3:0] OP_WR   = 4'd3;
  localparam logic [3:0] OP_MOV  = 4'd4;
  localparam logic [3:0] OP_CLR  = 4'd5;
  localparam logic [3:0] OP_SWAP = 4'd6;
  localparam logic [3:0] OP_INC  = 4'd7;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [WIDTH-1:0] r_tmp;
  logic [WIDTH-1:0] r_out_q;
  logic [AW-1:0]    r_swap_rs;
  logic             r_zero;
  logic             r_illegal;

  logic [3:0]       w_op;
  logic [AW-1:0]    w_rd;
  logic [AW-1:0]    w_rs;
  logic             w_accept;
  logic             w_bus_oe;
  logic [WIDTH-1:0] w_inc;

  assign w_op     = instr[3+2*AW -: 4];
  assign w_rd     = instr[2*AW-1 -: AW];
  assign w_rs     = instr[AW-1:0];
  assign w_accept = instr_valid && (r_state == S_IDLE);
  assign w_inc    = r_regs[w_rd] + WIDTH'(1);
  assign w_bus_oe = (r_state == S_DRIVE);

  assign ready   = (r_state == S_IDLE);
  assign zero    = r_zero;
  assign illegal = r_illegal;
  assign bus     = w_bus_oe ? r_out_q : {WIDTH{1'bz}};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_op == OP_RD)   w_next_state = S_DRIVE;
        if (w_accept && w_op == OP_SWAP) w_next_state = S_SWAP2;
      end
      S_DRIVE: w_next_state = S_IDLE;
      S_SWAP2: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!grst) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_tmp     <= '0;
      r_out_q   <= '0;
      r_swap_rs <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_illegal <= w_accept && w_op[3];
      // second half of SWAP; the saved rd value lands in the saved rs slot
      if (r_state == S_SWAP2) begin
        r_regs[r_swap_rs] <= r_tmp;
        r_zero            <= (r_tmp == '0);
      end else if (w_accept) begin
        case (w_op)
          OP_LDI: begin
            r_regs[w_rd] <= imm;
            r_zero       <= (imm == '0);
          end
          OP_RD: r_out_q <= r_regs[w_rs];
          OP_WR: begin
            r_regs[w_rd] <= bus;
            r_zero       <= (bus == '0);
          end
          OP_MOV: begin
            r_regs[w_rd] <= r_regs[w_rs];
            r_zero       <= (r_regs[w_rs] == '0);
          end
          OP_CLR: begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_zero <= 1'b1;
          end
          OP_SWAP: begin
            r_tmp        <= r_regs[w_rd];
            r_regs[w_rd] <= r_regs[w_rs];
            r_swap_rs    <= w_rs;
          end
          OP_INC: begin
            r_regs[w_rd] <= w_inc;
            r_zero       <= (w_inc == '0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed sequences on a 4x4 instance, randomised stream on an 8x8 instance.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-bit wide, 4-deep instance
  logic       s_grst, s_vld, s_ready, s_zero, s_ill, s_ext_en;
  logic [7:0] s_instr;
  logic [3:0] s_imm, s_ext;
  wire  [3:0] s_bus;
  assign s_bus = s_ext_en ? s_ext : 4'bz;

  // 8-bit wide, 8-deep instance
  logic       b_grst, b_vld, b_ready, b_zero, b_ill, b_ext_en;
  logic [9:0] b_instr;
  logic [7:0] b_imm, b_ext;
  wire  [7:0] b_bus;
  assign b_bus = b_ext_en ? b_ext : 8'bz;

  regfile_param #(.WIDTH(4), .DEPTH(4)) dut_s (
    .clk(clk), .grst(s_grst), .instr(s_instr), .instr_valid(s_vld), .ready(s_ready),
    .imm(s_imm), .bus(s_bus), .zero(s_zero), .illegal(s_ill)
  );

  regfile_param #(.WIDTH(8), .DEPTH(8)) dut_b (
    .clk(clk), .grst(b_grst), .instr(b_instr), .instr_valid(b_vld), .ready(b_ready),
    .imm(b_imm), .bus(b_bus), .zero(b_zero), .illegal(b_ill)
  );

  int n_chk = 0;
  int n_bad = 0;

  // reference state, index 0 = small instance, 1 = big instance
  logic [7:0] m_r [2][8];
  logic       m_zero [2];
  int         m_st [2];     // 0 idle, 1 drive, 2 swap2
  logic [7:0] m_tmp [2];
  int         m_swrs [2];
  logic [7:0] q_s [$];
  logic [7:0] q_b [$];
  logic       use_ovr = 1'b0;
  logic [7:0] ovr_val = 8'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int sel, input logic rst_n, input logic vld, input logic [3:0] op,
                     input int rd, input int rs, input logic [7:0] immv, input logic [7:0] extv);
    logic [7:0] mask;
    logic [7:0] rdv;
    logic [7:0] expv;
    logic [7:0] got_bus;
    logic       exp_ill, ext_en, oe;
    int         depth;
    mask   = (sel != 0) ? 8'hFF : 8'h0F;
    depth  = (sel != 0) ? 8 : 4;
    ext_en = rst_n && vld && (op == 4'd3) && (m_st[sel] == 0);
    if (sel != 0) begin
      b_grst = rst_n; b_vld = vld; b_instr = {op, 3'(rd), 3'(rs)};
      b_imm = immv; b_ext = extv; b_ext_en = ext_en;
    end else begin
      s_grst = rst_n; s_vld = vld; s_instr = {op, 2'(rd), 2'(rs)};
      s_imm = immv[3:0]; s_ext = extv[3:0]; s_ext_en = ext_en;
    end
    exp_ill = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_r[sel][i] = 8'h0;
      m_zero[sel] = 1'b1; m_st[sel] = 0; m_tmp[sel] = 8'h0;
    end else if (m_st[sel] == 1) begin
      m_st[sel] = 0;
    end else if (m_st[sel] == 2) begin
      m_r[sel][m_swrs[sel]] = m_tmp[sel];
      m_zero[sel] = (m_tmp[sel] == 8'h0);
      m_st[sel] = 0;
    end else if (vld) begin
      case (op)
        4'd0: ;
        4'd1: begin m_r[sel][rd] = immv & mask; m_zero[sel] = (m_r[sel][rd] == 8'h0); end
        4'd2: begin
          rdv = use_ovr ? ovr_val : m_r[sel][rs];
          if (sel != 0) q_b.push_back(rdv); else q_s.push_back(rdv);
          m_st[sel] = 1;
        end
        4'd3: begin m_r[sel][rd] = extv & mask; m_zero[sel] = (m_r[sel][rd] == 8'h0); end
        4'd4: begin m_r[sel][rd] = m_r[sel][rs]; m_zero[sel] = (m_r[sel][rd] == 8'h0); end
        4'd5: begin
          for (int i = 0; i < depth; i++) m_r[sel][i] = 8'h0;
          m_zero[sel] = 1'b1;
        end
        4'd6: begin
          m_tmp[sel] = m_r[sel][rd];
          m_r[sel][rd] = m_r[sel][rs];
          m_swrs[sel] = rs;
          m_st[sel] = 2;
        end
        4'd7: begin m_r[sel][rd] = (m_r[sel][rd] + 8'd1) & mask; m_zero[sel] = (m_r[sel][rd] == 8'h0); end
        default: exp_ill = 1'b1;
      endcase
    end
    use_ovr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (sel != 0) begin
      chk("ready", b_ready, m_st[sel] == 0);
      chk("zero", b_zero, m_zero[sel]);
      chk("illegal", b_ill, exp_ill);
      oe = dut_b.w_bus_oe;
      got_bus = b_bus;
    end else begin
      chk("ready", s_ready, m_st[sel] == 0);
      chk("zero", s_zero, m_zero[sel]);
      chk("illegal", s_ill, exp_ill);
      oe = dut_s.w_bus_oe;
      got_bus = {4'h0, s_bus};
    end
    chk("bus_oe", oe, m_st[sel] == 1);
    if (oe) begin
      if (sel != 0) begin
        chk("rd_pending", q_b.size(), 1);
        if (q_b.size() > 0) begin expv = q_b.pop_front(); chk("bus", got_bus, expv); end
      end else begin
        chk("rd_pending", q_s.size(), 1);
        if (q_s.size() > 0) begin expv = q_s.pop_front(); chk("bus", got_bus, expv); end
      end
    end
  endtask

  task automatic idle(input int sel);
    cyc(sel, 1'b1, 1'b0, 4'd0, 0, 0, 8'h0, 8'h0);
  endtask

  // RD with a hand-derived expected value, followed by the DRIVE-to-IDLE cycle
  task automatic rd_chk(input int sel, input int rs, input logic [7:0] expv);
    use_ovr = 1'b1;
    ovr_val = expv;
    cyc(sel, 1'b1, 1'b1, 4'd2, 0, rs, 8'h0, 8'h0);
    idle(sel);
  endtask

  task automatic ldi(input int sel, input int rd, input logic [7:0] v);
    cyc(sel, 1'b1, 1'b1, 4'd1, rd, 0, v, 8'h0);
  endtask

  initial begin
    logic [3:0] op;
    logic       rn, vld;
    s_ext_en = 1'b0; b_ext_en = 1'b0;
    b_grst = 1'b0; b_vld = 1'b0; b_instr = '0; b_imm = '0; b_ext = '0;

    // small instance: reset, then LDI R2=A and RD R2
    cyc(0, 1'b0, 1'b1, 4'd1, 1, 0, 8'h7, 8'h0);
    for (int i = 0; i < 4; i++) rd_chk(0, i, 8'h0);
    ldi(0, 2, 8'hA);
    rd_chk(0, 2, 8'hA);

    // SWAP R0<->R1 with valid held high through SWAP2
    ldi(0, 0, 8'h3);
    ldi(0, 1, 8'hC);
    cyc(0, 1'b1, 1'b1, 4'd6, 0, 1, 8'h0, 8'h0);
    cyc(0, 1'b1, 1'b1, 4'd6, 0, 1, 8'h0, 8'h0);
    rd_chk(0, 0, 8'hC);
    rd_chk(0, 1, 8'h3);

    // INC wrap then increment again
    ldi(0, 3, 8'hF);
    cyc(0, 1'b1, 1'b1, 4'd7, 3, 0, 8'h0, 8'h0);
    cyc(0, 1'b1, 1'b1, 4'd7, 3, 0, 8'h0, 8'h0);
    rd_chk(0, 3, 8'h1);

    // WR from external driver, then an undefined opcode
    cyc(0, 1'b1, 1'b1, 4'd3, 1, 0, 8'h0, 8'h5);
    rd_chk(0, 1, 8'h5);
    cyc(0, 1'b1, 1'b1, 4'hB, 1, 1, 8'h9, 8'h0);
    idle(0);
    rd_chk(0, 1, 8'h5);
    cyc(0, 1'b1, 1'b1, 4'd4, 2, 1, 8'h0, 8'h0);
    rd_chk(0, 2, 8'h5);

    // reset lands on the SWAP2 edge; the second half must not happen
    cyc(0, 1'b1, 1'b1, 4'd6, 1, 3, 8'h0, 8'h0);
    cyc(0, 1'b0, 1'b1, 4'd1, 0, 0, 8'h9, 8'h0);
    for (int i = 0; i < 4; i++) rd_chk(0, i, 8'h0);

    // CLR after loading non-zero values
    for (int i = 0; i < 4; i++) ldi(0, i, 8'(i + 6));
    cyc(0, 1'b1, 1'b1, 4'd5, 0, 0, 8'h0, 8'h0);
    for (int i = 0; i < 4; i++) rd_chk(0, i, 8'h0);
    idle(0);
    chk("small_q_empty", q_s.size(), 0);

    // big instance: randomised stream against the reference model
    cyc(1, 1'b0, 1'b0, 4'd0, 0, 0, 8'h0, 8'h0);
    for (int n = 0; n < 800; n++) begin
      op  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      vld = ($urandom_range(0, 3) != 0);
      rn  = ($urandom_range(0, 99) != 0);
      cyc(1, rn, vld, op, $urandom_range(0, 7), $urandom_range(0, 7),
          ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom),
          ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom));
    end
    idle(1);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1'b1, 1'b1, 4'd2, 0, i, 8'h0, 8'h0);
      idle(1);
    end
    chk("big_q_empty", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
